// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Definitions shared by the SPI receive and transmit sides of the edge
// detection link: the word size, the transmitter state encoding and the
// frame geometry of the image streamed from the MCU.
// No ports (package).
// ---------------------------------------------------------------------------
package spi_pkg;

    // Word size used on the SPI link in both directions.
    localparam int SPI_MESSAGE_BITS = 16;

    // Geometry of one image frame delivered by the MCU.
    localparam int FRAME_WIDTH  = 320;
    localparam int FRAME_HEIGHT = 240;
    localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;

    // Transmitter sequencing: wait for a frame, load a word, shift it out.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spiTxState_t;

    // Linear pixel index of (x, y) within a frame, row-major.
    function automatic int pixelIndex(input int x, input int y);
        return y * FRAME_WIDTH + x;
    endfunction

endpackage

// File: rtl/spi_result_transmitter_sync.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous SPI pin into the mainClk domain through two flops,
// keeps one more flop of history and reports single-cycle rise/fall pulses.
// Ports:
//   clk      - sampling clock (mainClk)
//   nreset   - synchronous active-low reset; all flops take IDLE_LEVEL
//   async_i  - asynchronous pin level
//   rise_o   - one-cycle pulse on a synchronized 0->1 transition
//   fall_o   - one-cycle pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module sync_edge_detect #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic nreset,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two-flop synchronizer followed by a history flop. Reset loads the
    // pin's idle level so that leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            meta_q <= IDLE_LEVEL;
            sync_q <= IDLE_LEVEL;
            prev_q <= IDLE_LEVEL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = ~prev_q & sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/spi_result_transmitter.sv
// ---------------------------------------------------------------------------
// spi_result_transmitter
// Returns edge-detection results to the MCU over SPI (mode 0). Results are
// buffered in a small FIFO; each word of an MCU frame shifts one buffered
// word MSB-first on sdo, or FILL_WORD when the FIFO has run dry. spiClk and
// ncs are oversampled on mainClk, so there is a single clock domain.
// Ports:
//   mainClk       - system clock, at least 8x spiClk
//   nreset        - synchronous active-low reset
//   spiClk, ncs   - SPI clock and chip select from the MCU (asynchronous)
//   sdo           - serial data out, MSB first
//   sdoEnable     - high while a frame is being served (pad tristate)
//   resultWord    - result word from the filter pipeline
//   resultValid   - resultWord is valid
//   resultReady   - FIFO not full
//   wordsPending  - FIFO occupancy
//   underrun      - one-cycle pulse when FILL_WORD is loaded
//   txAbort       - one-cycle pulse when ncs rises mid-word
// Build option: define SPI_TX_VALID_TAG_EN to replace the MSB of every
// transmitted word with a tag (1 = FIFO word, 0 = filler).
// ---------------------------------------------------------------------------
module spi_result_transmitter
    import spi_pkg::*;
#(
    parameter int                      MESSAGE_BITS = SPI_MESSAGE_BITS,
    parameter int                      FIFO_DEPTH   = 4,
    parameter logic [MESSAGE_BITS-1:0] FILL_WORD    = '0
) (
    input  logic                          mainClk,
    input  logic                          nreset,
    input  logic                          spiClk,
    input  logic                          ncs,
    output logic                          sdo,
    output logic                          sdoEnable,
    input  logic [MESSAGE_BITS-1:0]       resultWord,
    input  logic                          resultValid,
    output logic                          resultReady,
    output logic [$clog2(FIFO_DEPTH):0]   wordsPending,
    output logic                          underrun,
    output logic                          txAbort
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(MESSAGE_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(MESSAGE_BITS - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic sckFall;
    logic sckRiseUnused;
    logic ncsFall;
    logic ncsRise;

    spiTxState_t state_q, state_d;
    logic [MESSAGE_BITS-1:0] shiftReg_q, shiftReg_d;
    logic [BIT_W-1:0]        bitCount_q, bitCount_d;

    logic [MESSAGE_BITS-1:0] fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wrPtr_q;
    logic [PTR_W-1:0]        rdPtr_q;
    logic [CNT_W-1:0]        count_q;

    logic                    fifoEmpty;
    logic                    fifoFull;
    logic                    push;
    logic                    pop;
    logic                    lastBit;
    logic [MESSAGE_BITS-1:0] headWord;
    logic [MESSAGE_BITS-1:0] loadWord;

    // spiClk idles low in mode 0; only its falling edge moves the shifter,
    // so the rising-edge pulse is left unused.
    sync_edge_detect #(.IDLE_LEVEL(1'b0)) sckSync (
        .clk     (mainClk),
        .nreset  (nreset),
        .async_i (spiClk),
        .rise_o  (sckRiseUnused),
        .fall_o  (sckFall)
    );

    sync_edge_detect #(.IDLE_LEVEL(1'b1)) ncsSync (
        .clk     (mainClk),
        .nreset  (nreset),
        .async_i (ncs),
        .rise_o  (ncsRise),
        .fall_o  (ncsFall)
    );

    assign fifoEmpty = (count_q == '0);
    assign fifoFull  = (count_q == DEPTH_CNT);
    assign push      = resultValid & ~fifoFull;
    // A frame that ends while in LOAD takes nothing out of the FIFO.
    assign pop       = (state_q == LOAD) & ~ncsRise & ~fifoEmpty;
    assign lastBit   = sckFall & (bitCount_q == LAST_BIT);
    assign headWord  = fifoMem_q[rdPtr_q];

`ifdef SPI_TX_VALID_TAG_EN
    assign loadWord = fifoEmpty ? {1'b0, FILL_WORD[MESSAGE_BITS-2:0]}
                                : {1'b1, headWord[MESSAGE_BITS-2:0]};
`else
    assign loadWord = fifoEmpty ? FILL_WORD : headWord;
`endif

    // State register together with the shifter and its bit counter.
    always_ff @(posedge mainClk) begin
        if (!nreset) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            bitCount_q <= '0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            bitCount_q <= bitCount_d;
        end
    end

    // Next-state logic. ncs rising always wins, including on the final bit
    // of a word, so a finished frame never starts loading another word.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        bitCount_d = bitCount_q;
        case (state_q)
            IDLE: begin
                if (ncsFall) state_d = LOAD;
            end
            LOAD: begin
                if (ncsRise) begin
                    state_d = IDLE;
                end else begin
                    shiftReg_d = loadWord;
                    bitCount_d = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (ncsRise) begin
                    state_d = IDLE;
                end else if (sckFall) begin
                    shiftReg_d = shiftReg_q << 1;
                    bitCount_d = bitCount_q + 1'b1;
                    if (bitCount_q == LAST_BIT) state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state. Any ncs rise in SHIFT cuts a
    // loaded word short unless it coincides with that word's last bit.
    always_comb begin
        sdo       = 1'b0;
        sdoEnable = 1'b0;
        underrun  = 1'b0;
        txAbort   = 1'b0;
        case (state_q)
            LOAD: begin
                sdoEnable = 1'b1;
                underrun  = ~ncsRise & fifoEmpty;
            end
            SHIFT: begin
                sdoEnable = 1'b1;
                sdo       = shiftReg_q[MESSAGE_BITS-1];
                txAbort   = ncsRise & ~lastBit;
            end
            default: ;
        endcase
    end

    // FIFO bookkeeping. A simultaneous push and pop leaves the count alone.
    always_ff @(posedge mainClk) begin
        if (!nreset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + 1'b1;
            if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage needs no reset; emptiness is tracked by the count.
    always_ff @(posedge mainClk) begin
        if (push) fifoMem_q[wrPtr_q] <= resultWord;
    end

    assign resultReady  = ~fifoFull;
    assign wordsPending = count_q;

endmodule

// File: tb/tb_spi_result_transmitter.sv
// ---------------------------------------------------------------------------
// tb_spi_result_transmitter
// Acts as the MCU (mode 0, spiClk = mainClk/8) and as the filter pipeline.
// Received words are compared with a queue-based model of the result FIFO.
// ---------------------------------------------------------------------------
module tb_spi_result_transmitter;

    localparam int          DEPTH = 4;
    localparam logic [15:0] FILL  = 16'h0000;

    logic        mainClk = 1'b0;
    logic        nreset;
    logic        spiClk;
    logic        ncs;
    logic        sdo;
    logic        sdoEnable;
    logic [15:0] resultWord;
    logic        resultValid;
    logic        resultReady;
    logic [2:0]  wordsPending;
    logic        underrun;
    logic        txAbort;

    int checks = 0;
    int failures = 0;
    int underrunSeen = 0;
    int abortSeen = 0;
    int expUnderrun = 0;
    int expAbort = 0;
    logic [15:0] modelQ[$];

    spi_result_transmitter dut (
        .mainClk      (mainClk),
        .nreset       (nreset),
        .spiClk       (spiClk),
        .ncs          (ncs),
        .sdo          (sdo),
        .sdoEnable    (sdoEnable),
        .resultWord   (resultWord),
        .resultValid  (resultValid),
        .resultReady  (resultReady),
        .wordsPending (wordsPending),
        .underrun     (underrun),
        .txAbort      (txAbort)
    );

    always #5 mainClk = ~mainClk;

    // Count status pulses as the MCU side would see them.
    always @(negedge mainClk) begin
        if (nreset) begin
            if (underrun) underrunSeen++;
            if (txAbort)  abortSeen++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // What the MCU should see for a word: FIFO words carry a valid tag in
    // the MSB when tagging is built in; fillers are always FILL.
    function automatic logic [15:0] txView(input logic [15:0] w, input bit fromFifo);
        logic [15:0] r;
        r = fromFifo ? w : FILL;
`ifdef SPI_TX_VALID_TAG_EN
        r[15] = fromFifo;
`endif
        return r;
    endfunction

    // The word the next LOAD should produce, consuming the model FIFO.
    task automatic modelLoad(output logic [15:0] w);
        if (modelQ.size() > 0) begin
            w = txView(modelQ.pop_front(), 1'b1);
        end else begin
            w = txView(FILL, 1'b0);
            expUnderrun++;
        end
    endtask

    // One pipeline push with a single-cycle valid.
    task automatic applyStimulus(input logic [15:0] w);
        @(negedge mainClk);
        checkOutput("readyBeforePush", resultReady, modelQ.size() < DEPTH);
        resultValid = 1'b1;
        resultWord  = w;
        @(negedge mainClk);
        resultValid = 1'b0;
        if (modelQ.size() < DEPTH) modelQ.push_back(w);
        checkOutput("pendingAfterPush", wordsPending, modelQ.size());
    endtask

    // Full frame of nWords words; ncs rises together with the last falling
    // spiClk edge, so no extra word is loaded.
    task automatic runFrame(input int nWords);
        logic [15:0] exp;
        logic [15:0] rx;
        @(negedge mainClk);
        ncs = 1'b0;
        repeat (8) @(negedge mainClk);
        for (int w = 0; w < nWords; w++) begin
            modelLoad(exp);
            rx = '0;
            for (int b = 0; b < 16; b++) begin
                rx = {rx[14:0], sdo};
                spiClk = 1'b1;
                repeat (4) @(negedge mainClk);
                spiClk = 1'b0;
                if (w == nWords - 1 && b == 15) ncs = 1'b1;
                repeat (4) @(negedge mainClk);
            end
            checkOutput($sformatf("rxWord%0d", w), rx, exp);
        end
        repeat (4) @(negedge mainClk);
        checkOutput("frameEndSdoEnable", sdoEnable, 0);
    endtask

    // Start a frame and stop after nBits bits with ncs still low.
    task automatic startPartial(input int nBits);
        logic [15:0] exp;
        modelLoad(exp);
        @(negedge mainClk);
        ncs = 1'b0;
        repeat (8) @(negedge mainClk);
        for (int b = 0; b < nBits; b++) begin
            spiClk = 1'b1;
            repeat (4) @(negedge mainClk);
            spiClk = 1'b0;
            repeat (4) @(negedge mainClk);
        end
    endtask

    // Hold valid on a word until the FIFO has room, bounded in cycles.
    task automatic pushHeld(input logic [15:0] w);
        bit got;
        got = 1'b0;
        @(negedge mainClk);
        resultValid = 1'b1;
        resultWord  = w;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge mainClk);
            if (resultReady) begin
                checkOutput("pendingAtFirstPop", wordsPending, DEPTH - 1);
                @(negedge mainClk);
                resultValid = 1'b0;
                modelQ.push_back(w);
                got = 1'b1;
            end
        end
        if (!got) begin
            resultValid = 1'b0;
            checkOutput("pushHeldTimeout", 0, 1);
        end
    endtask

    initial begin
        nreset      = 1'b0;
        spiClk      = 1'b0;
        ncs         = 1'b1;
        resultValid = 1'b0;
        resultWord  = '0;
        repeat (3) @(negedge mainClk);
        nreset = 1'b1;
        @(negedge mainClk);

        // Reset state.
        checkOutput("rstSdo", sdo, 0);
        checkOutput("rstSdoEnable", sdoEnable, 0);
        checkOutput("rstReady", resultReady, 1);
        checkOutput("rstPending", wordsPending, 0);
        checkOutput("rstUnderrun", underrun, 0);
        checkOutput("rstAbort", txAbort, 0);

        // Single word.
        applyStimulus(16'hA5C3);
        runFrame(1);
        checkOutput("singlePending", wordsPending, 0);
        checkOutput("singleUnderrun", underrunSeen, expUnderrun);

        // Underrun, then a word whose MSB may be replaced by a tag.
        runFrame(1);
        checkOutput("emptyUnderrun", underrunSeen, expUnderrun);
        applyStimulus(16'h1234);
        runFrame(1);

        // Three-word burst.
        applyStimulus(16'h1111);
        applyStimulus(16'h2222);
        applyStimulus(16'h3333);
        runFrame(3);
        checkOutput("burstReady", resultReady, 1);
        checkOutput("burstUnderrun", underrunSeen, expUnderrun);

        // FIFO full; fifth word waits for the first pop.
        for (int i = 0; i < DEPTH; i++) applyStimulus(16'($urandom));
        checkOutput("fullReady", resultReady, 0);
        checkOutput("fullPending", wordsPending, DEPTH);
        fork
            runFrame(1);
            pushHeld(16'h5A5A);
        join
        checkOutput("peakPending", wordsPending, DEPTH);
        runFrame(4);
        checkOutput("drainPending", wordsPending, 0);

        // Abort after 7 bits.
        applyStimulus(16'hFFFF);
        startPartial(7);
        repeat (2) @(negedge mainClk);
        ncs = 1'b1;
        expAbort++;
        repeat (4) @(negedge mainClk);
        checkOutput("abortSdoEnable", sdoEnable, 0);
        repeat (4) @(negedge mainClk);
        checkOutput("abortCount", abortSeen, expAbort);
        runFrame(1);
        checkOutput("afterAbortUnderrun", underrunSeen, expUnderrun);

        // Reset in the middle of bit 9.
        applyStimulus(16'hC0DE);
        applyStimulus(16'hBEEF);
        startPartial(9);
        spiClk = 1'b1;
        repeat (2) @(negedge mainClk);
        nreset = 1'b0;
        ncs    = 1'b1;
        spiClk = 1'b0;
        @(negedge mainClk);
        checkOutput("midRstSdo", sdo, 0);
        checkOutput("midRstSdoEnable", sdoEnable, 0);
        checkOutput("midRstPending", wordsPending, 0);
        checkOutput("midRstReady", resultReady, 1);
        nreset = 1'b1;
        modelQ.delete();
        runFrame(1);
        checkOutput("afterRstUnderrun", underrunSeen, expUnderrun);

        // Randomized pushes and bursts.
        for (int it = 0; it < 8; it++) begin
            int nPush;
            nPush = $urandom_range(DEPTH - modelQ.size(), 0);
            for (int k = 0; k < nPush; k++) applyStimulus(16'($urandom));
            runFrame($urandom_range(3, 1));
            checkOutput("randPending", wordsPending, modelQ.size());
            checkOutput("randUnderrun", underrunSeen, expUnderrun);
            checkOutput("randAbort", abortSeen, expAbort);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
